// File: rtl/fb_freq_counter_pkg.sv
// Shared types and constants for the divided-DCO frequency counter.
package fb_freq_counter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StGate
  } state_e;

  localparam logic [1:0] TAP_DIV1 = 2'd0;
  localparam logic [1:0] TAP_DIV2 = 2'd1;
  localparam logic [1:0] TAP_DIV4 = 2'd2;
  localparam logic [1:0] TAP_DIV8 = 2'd3;

endpackage

// File: rtl/fb_freq_counter_if.sv
// Control and result bundle between the frequency counter and its consumer.
interface fb_freq_counter_if #(
  parameter int unsigned COUNT_W = 16
) ();
  import fb_freq_counter_pkg::*;

  logic [1:0]         sel_i;
  logic               enable_i;
  logic [COUNT_W-1:0] count_o;
  logic               valid_o;
  logic               overflow_o;
  logic               busy_o;

  modport master (
    output sel_i,
    output enable_i,
    input  count_o,
    input  valid_o,
    input  overflow_o,
    input  busy_o
  );

  modport slave (
    input  sel_i,
    input  enable_i,
    output count_o,
    output valid_o,
    output overflow_o,
    output busy_o
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous tap followed by a rising-edge detector.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else if (clear_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/fb_freq_counter.sv
// Counts rising edges of the selected divider tap over back-to-back gate windows of clk_i.
module fb_freq_counter
  import fb_freq_counter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1024,
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        taps_i,
  fb_freq_counter_if.slave  bus
);

  localparam int unsigned GateW   = $clog2(GATE_CYCLES);
  localparam int unsigned SettleW = $clog2(SYNC_STAGES + 2);
  localparam logic [GateW-1:0]   GateLast   = GateW'(GATE_CYCLES - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SYNC_STAGES);
  localparam logic [COUNT_W-1:0] CountMax   = '1;

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [GateW-1:0]   gate_q, gate_d;
  logic [COUNT_W-1:0] acc_q, acc_d, acc_inc;
  logic               sat_q, sat_d, sat_now;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               clear;
  logic               tap_rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(clear),
    .async_i(taps_i[sel_q]),
    .edge_o (tap_rise)
  );

  assign sat_now = tap_rise && (acc_q == CountMax);
  assign acc_inc = (tap_rise && !sat_now) ? acc_q + 1'b1 : acc_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable_i) begin
          state_d  = StSettle;
          sel_d    = bus.sel_i;
          settle_d = '0;
          clear    = 1'b1;
        end
      end
      StSettle, StGate: begin
        // Deassertion wins over a select change; both discard the partial window.
        if (!bus.enable_i) begin
          state_d = StIdle;
        end else if (bus.sel_i != sel_q) begin
          state_d  = StSettle;
          sel_d    = bus.sel_i;
          settle_d = '0;
          clear    = 1'b1;
        end else if (state_q == StSettle) begin
          settle_d = settle_q + 1'b1;
          if (settle_q == SettleLast) begin
            state_d = StGate;
            gate_d  = '0;
            acc_d   = '0;
            sat_d   = 1'b0;
          end
        end else if (gate_q == GateLast) begin
          count_d = acc_inc;
          ovf_d   = sat_q | sat_now;
          valid_d = 1'b1;
          acc_d   = '0;
          sat_d   = 1'b0;
          gate_d  = '0;
        end else begin
          gate_d = gate_q + 1'b1;
          acc_d  = acc_inc;
          sat_d  = sat_q | sat_now;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      settle_q <= '0;
      gate_q   <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.count_o    = count_q;
  assign bus.valid_o    = valid_q;
  assign bus.overflow_o = ovf_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_fb_freq_counter.sv
// Self-checking bench: tap-period table plus select-change, disable, reset and saturation cases.
module tb_fb_freq_counter;
  import fb_freq_counter_pkg::*;

  localparam int unsigned Gate     = 1024;
  localparam int unsigned Sync     = 2;
  localparam int unsigned FirstLat = 1 + Sync + 1 + Gate;  // edges from enable drive to valid
  localparam int unsigned ChgLat   = 1 + Sync + Gate;      // edges after the select-sampling edge

  typedef struct {
    logic [1:0]  sel;
    int unsigned half;
    int unsigned wins;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] taps_a, taps_b;
  int unsigned half_a[4], half_b[4], ph_a[4], ph_b[4];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [16:0] q_a[$];
  logic [4:0]  q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fb_freq_counter_if #(.COUNT_W(16)) bus_a ();
  fb_freq_counter_if #(.COUNT_W(4))  bus_b ();

  fb_freq_counter #(.GATE_CYCLES(Gate), .COUNT_W(16), .SYNC_STAGES(Sync)) dut_a (
    .clk_i(clk), .reset_i(reset), .taps_i(taps_a), .bus(bus_a)
  );
  fb_freq_counter #(.GATE_CYCLES(Gate), .COUNT_W(4), .SYNC_STAGES(Sync)) dut_b (
    .clk_i(clk), .reset_i(reset), .taps_i(taps_b), .bus(bus_b)
  );

  // Tap generator: half period in clk cycles, 0 holds the tap high; updates 3 ns after the edge.
  initial begin
    taps_a = '0;
    taps_b = '0;
    for (int k = 0; k < 4; k++) begin
      ph_a[k] = 0;
      ph_b[k] = 0;
    end
    forever begin
      @(posedge clk);
      #3;
      for (int k = 0; k < 4; k++) begin
        if (half_a[k] == 0) taps_a[k] = 1'b1;
        else begin
          ph_a[k]++;
          if (ph_a[k] >= half_a[k]) begin
            ph_a[k] = 0;
            taps_a[k] = ~taps_a[k];
          end
        end
        if (half_b[k] == 0) taps_b[k] = 1'b1;
        else begin
          ph_b[k]++;
          if (ph_b[k] >= half_b[k]) begin
            ph_b[k] = 0;
            taps_b[k] = ~taps_b[k];
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards: every valid_o pops one expected {overflow, count}.
  int last_va = 0;
  bit armed_a = 1'b0;
  logic [1:0] sel_seen_a = 2'd0;
  always @(negedge clk) begin
    logic [16:0] e;
    if (!bus_a.busy_o || bus_a.sel_i != sel_seen_a) armed_a = 1'b0;
    sel_seen_a = bus_a.sel_i;
    if (bus_a.valid_o) begin
      check("a valid expected", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a count", 32'(bus_a.count_o), 32'(e[15:0]));
        check("a overflow", 32'(bus_a.overflow_o), 32'(e[16]));
      end
      if (armed_a) check("a valid spacing", 32'(cyc - last_va), Gate);
      armed_a = 1'b1;
      last_va = cyc;
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (bus_b.valid_o) begin
      check("b valid expected", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b count", 32'(bus_b.count_o), 32'(e[3:0]));
        check("b overflow", 32'(bus_b.overflow_o), 32'(e[4]));
      end
    end
  end

  // Returns the number of rising edges until valid_o is seen; bounded by budget.
  task automatic wait_valid(input bit on_b, input int budget, output int n);
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = on_b ? bus_b.valid_o : bus_a.valid_o;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s valid timeout: none within %0d cycles", on_b ? "b" : "a", budget);
      if (on_b) q_b.delete();
      else q_a.delete();
    end
  endtask

  initial begin
    vec_t vecs[5];
    int n;
    vecs[0] = '{TAP_DIV8, 8, 3, 16'd64};
    vecs[1] = '{TAP_DIV1, 2, 2, 16'd256};
    vecs[2] = '{TAP_DIV2, 4, 1, 16'd128};
    vecs[3] = '{TAP_DIV4, 0, 2, 16'd0};
    vecs[4] = '{TAP_DIV4, 16, 1, 16'd32};

    half_a = '{2, 4, 16, 8};
    half_b = '{2, 0, 0, 0};
    bus_a.enable_i = 1'b0;
    bus_a.sel_i    = TAP_DIV8;
    bus_b.enable_i = 1'b0;
    bus_b.sel_i    = TAP_DIV1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset a count", 32'(bus_a.count_o), 0);
    check("reset a valid", 32'(bus_a.valid_o), 0);
    check("reset a overflow", 32'(bus_a.overflow_o), 0);
    check("reset a busy", 32'(bus_a.busy_o), 0);
    check("reset b count", 32'(bus_b.count_o), 0);
    check("reset b busy", 32'(bus_b.busy_o), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Saturation with a 4-bit counter, then a slow tap clears the overflow flag.
    q_b.push_back({1'b1, 4'd15});
    bus_b.enable_i = 1'b1;
    wait_valid(1'b1, FirstLat + 20, n);
    check("b first latency", n, FirstLat);
    bus_b.enable_i = 1'b0;
    half_b[0] = 256;
    repeat (600) @(negedge clk);
    q_b.push_back({1'b0, 4'd2});
    bus_b.enable_i = 1'b1;
    wait_valid(1'b1, FirstLat + 20, n);
    bus_b.enable_i = 1'b0;

    // Tap/period table on the 16-bit instance.
    for (int v = 0; v < 5; v++) begin
      half_a[vecs[v].sel] = vecs[v].half;
      bus_a.sel_i = vecs[v].sel;
      repeat (40) @(negedge clk);
      for (int w = 0; w < int'(vecs[v].wins); w++) q_a.push_back({1'b0, vecs[v].exp});
      bus_a.enable_i = 1'b1;
      wait_valid(1'b0, FirstLat + 20, n);
      check("a first latency", n, FirstLat);
      check("a busy running", 32'(bus_a.busy_o), 1);
      for (int w = 1; w < int'(vecs[v].wins); w++) wait_valid(1'b0, Gate + 20, n);
      bus_a.enable_i = 1'b0;
      @(negedge clk);
      check("a busy after disable", 32'(bus_a.busy_o), 0);
    end
    half_a = '{2, 4, 16, 8};
    repeat (40) @(negedge clk);

    // Select change mid-window: old window dropped, new one measures tap 1.
    bus_a.sel_i = TAP_DIV8;
    q_a.push_back({1'b0, 16'd64});
    bus_a.enable_i = 1'b1;
    wait_valid(1'b0, FirstLat + 20, n);
    repeat (500) @(negedge clk);
    bus_a.sel_i = TAP_DIV2;
    q_a.push_back({1'b0, 16'd128});
    @(posedge clk);
    wait_valid(1'b0, ChgLat + 20, n);
    check("a select change latency", n, ChgLat);
    bus_a.enable_i = 1'b0;
    repeat (5) @(negedge clk);

    // Disable mid-window: no result, previous count held.
    bus_a.sel_i = TAP_DIV8;
    q_a.push_back({1'b0, 16'd64});
    bus_a.enable_i = 1'b1;
    wait_valid(1'b0, FirstLat + 20, n);
    repeat (300) @(negedge clk);
    bus_a.enable_i = 1'b0;
    @(negedge clk);
    check("a busy drop", 32'(bus_a.busy_o), 0);
    repeat (1200) @(negedge clk);
    check("a count held", 32'(bus_a.count_o), 64);
    check("a overflow held", 32'(bus_a.overflow_o), 0);

    // Asynchronous reset mid-window, released with enable high.
    q_a.push_back({1'b0, 16'd64});
    bus_a.enable_i = 1'b1;
    wait_valid(1'b0, FirstLat + 20, n);
    repeat (200) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async reset count", 32'(bus_a.count_o), 0);
    check("async reset busy", 32'(bus_a.busy_o), 0);
    check("async reset overflow", 32'(bus_a.overflow_o), 0);
    check("async reset valid", 32'(bus_a.valid_o), 0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    q_a.push_back({1'b0, 16'd64});
    wait_valid(1'b0, FirstLat + 20, n);
    check("a latency after reset", n, FirstLat);
    bus_a.enable_i = 1'b0;
    repeat (5) @(negedge clk);

    check("a leftover expected", q_a.size(), 0);
    check("b leftover expected", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_freq_counter.md
# fb_freq_counter

Measures the frequency of one divided DCO tap (div1/div2/div4/div8 from the ripple divider) by counting its rising edges over a fixed gate window of the system clock. It sits on the receiving end of the divider outputs, in the clk_i domain, and supplies the loop controller and debug readout with a per-window edge count. Tap selection is run-time; every window result is reported with a one-cycle valid strobe.

## Interface
- GATE_CYCLES, 1024: gate window length in clk_i cycles; ≥ 2.
- COUNT_W, 16: width of the edge count and result.
- SYNC_STAGES, 2: synchronizer depth for the selected tap; ≥ 2.

- clk_i  in  1  system/reference clock.
- reset_i  in  1  asynchronous, active-high reset.
- taps_i  in  4  asynchronous divider taps; bit0 div1, bit1 div2, bit2 div4, bit3 div8.
- sel_i  in  2  tap index to measure.
- enable_i  in  1  measurement run request.
- count_o  out  COUNT_W  result of last completed window; held between windows.
- valid_o  out  1  one-cycle pulse when count_o updates.
- overflow_o  out  1  last reported window saturated.
- busy_o  out  1  high in SETTLE or GATE.

## Operation
- Reset (asynchronous, immediate): state IDLE; count_o 0, valid_o 0, overflow_o 0, busy_o 0; accumulator, gate counter, synchronizer and edge register cleared.
- Selected tap = taps_i[sel_i]; mux output feeds the SYNC_STAGES flop synchronizer, then a rising-edge detector (edge = sync & ~prev).
- States:
  - IDLE: busy_o 0. enable_i=1 → SETTLE, latch sel_i.
  - SETTLE: SYNC_STAGES+1 cycles; synchronizer and prev register fill; no edges counted. Then → GATE with accumulator 0, gate counter 0.
  - GATE: each cycle gate counter increments; detected edge increments accumulator (saturating at 2^COUNT_W−1, sticky sat flag). In cycle GATE_CYCLES−1 (terminal): count_o ← accumulator + edge (saturated), overflow_o ← sat flag (or saturation this cycle), accumulator, sat flag and gate counter restart at 0; state stays GATE. Windows are back-to-back with no dead cycle.
- enable_i=0 in SETTLE/GATE → IDLE next cycle; partial window discarded; count_o/overflow_o hold.
- sel_i ≠ latched select in SETTLE/GATE → SETTLE with new select; partial window discarded, no valid_o.
- sel_i change and enable_i deassertion in the same cycle: enable_i wins (→ IDLE).
- Edge on the terminal cycle belongs to the ending window; edge on the following cycle belongs to the new window.
- Measurable input: tap frequency < f_clk/2 (each high and low phase ≥ 1 clk_i period after synchronization). Faster taps undercount; no detection of aliasing is required.

## Timing
- valid_o asserts the cycle after the terminal GATE cycle, concurrent with new count_o/overflow_o values; exactly one cycle wide.
- First valid_o after enable_i rises in IDLE: 1 (IDLE→SETTLE) + SYNC_STAGES+1 + GATE_CYCLES cycles later; subsequent every GATE_CYCLES cycles.
- Input edge to counted: SYNC_STAGES+1 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package fb_freq_counter_pkg: state enum (IDLE, SETTLE, GATE), tap index constants TAP_DIV1=0, TAP_DIV2=1, TAP_DIV4=2, TAP_DIV8=3.
- Sub-module sync_edge_detect (SYNC_STAGES parameter; async in, rising-edge pulse out, clear input used on SETTLE entry and reset).
- Gate counter width $clog2(GATE_CYCLES).

## Test plan
- Tap div8 (sel_i=3) toggled with period 16 clk_i cycles, enable_i held: every valid_o reports count_o=64 (GATE_CYCLES=1024), overflow_o=0, spacing exactly 1024 cycles.
- COUNT_W=4, tap period 4 cycles, GATE_CYCLES=1024: count_o=15, overflow_o=1; then tap period 512 → next window count_o=2, overflow_o=0.
- Static tap (held 1 through enable): count_o=0 every window; no spurious edge from settle.
- sel_i 3→1 at gate cycle 500: no valid_o for that window; next valid_o exactly 1+SYNC_STAGES+GATE_CYCLES cycles after change, count reflects tap 1.
- enable_i low mid-window: busy_o 0 next cycle, no valid_o, count_o keeps previous 64.
- reset_i pulse mid-window (not clock-aligned): outputs 0 immediately; after release with enable_i high, first valid_o after full settle+gate with correct count.
